// File: rtl/bitmap_wave_player.sv
// Bitmap waveform player: replays a writable column memory onto ROWS lines with
// per-column hold, one-shot/loop/ping-pong modes. Optional macro: BLANK_GAP_EN.
module bitmap_wave_player #(
  parameter  int ROWS   = 12,
  parameter  int COLS   = 32,
  parameter  int HOLD_W = 8,
  localparam int AW     = $clog2(COLS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [ROWS-1:0]   wr_data,
  input  logic              start,
  input  logic              stop,
  input  logic [1:0]        mode,
  input  logic [AW:0]       len,
  input  logic [HOLD_W-1:0] hold,
  output logic [ROWS-1:0]   signals,
  output logic              busy,
  output logic              done,
  output logic [AW-1:0]     col_idx
);

`ifdef BLANK_GAP_EN
  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;
`else
  typedef enum logic [1:0] {IDLE, PLAY} state_t;
`endif

  state_t            state, state_n;
  logic [ROWS-1:0]   mem [COLS];
  logic [HOLD_W-1:0] cnt, cnt_n, hold_q;
  logic [AW:0]       len_q;
  logic [1:0]        mode_q;
  logic [AW-1:0]     col_n, turn_col;
  logic              dir, dir_n;
  logic              launch, enter, blank, turn, busy_n, done_n;
  logic              len_ok, is_loop, is_pp, last;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign len_ok  = (len != '0) && (32'(len) <= 32'(COLS));
  assign is_loop = (mode_q == 2'b01);
  assign is_pp   = (mode_q == 2'b10);
  assign last    = ({1'b0, col_idx} == len_q - 1'b1);

  always_comb begin
    state_n  = state;
    col_n    = col_idx;
    cnt_n    = cnt;
    dir_n    = dir;
    busy_n   = busy;
    done_n   = 1'b0;
    launch   = 1'b0;
    enter    = 1'b0;
    blank    = 1'b0;
    turn     = 1'b0;
    turn_col = '0;
    case (state)
      IDLE: begin
        if (start && !stop && len_ok) begin
          launch  = 1'b1;
          state_n = PLAY;
          col_n   = '0;
          cnt_n   = 1;
          dir_n   = 1'b0;
          enter   = 1'b1;
          busy_n  = 1'b1;
        end
      end
      PLAY: begin
        if (stop) begin
          state_n = IDLE;
          col_n   = '0;
          cnt_n   = '0;
          busy_n  = 1'b0;
          blank   = 1'b1;
        end else if (cnt == hold_q) begin
          cnt_n = 1;
          if (is_pp) begin
            // len=1 ping-pong has no turnaround: column 0 is simply re-entered
            if (len_q == 1) begin
              enter = 1'b1;
              col_n = '0;
            end else if (!dir && last) begin
              dir_n = 1'b1; turn = 1'b1; turn_col = col_idx - 1'b1;
            end else if (dir && col_idx == '0) begin
              dir_n = 1'b0; turn = 1'b1; turn_col = col_idx + 1'b1;
            end else begin
              enter = 1'b1;
              col_n = dir ? col_idx - 1'b1 : col_idx + 1'b1;
            end
          end else if (last) begin
            if (is_loop) begin
              turn = 1'b1; turn_col = '0;
            end else begin
              state_n = IDLE;
              col_n   = '0;
              cnt_n   = '0;
              busy_n  = 1'b0;
              done_n  = 1'b1;
              blank   = 1'b1;
            end
          end else begin
            enter = 1'b1;
            col_n = col_idx + 1'b1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
`ifdef BLANK_GAP_EN
      GAP: begin
        if (stop) begin
          state_n = IDLE;
          col_n   = '0;
          cnt_n   = '0;
          busy_n  = 1'b0;
          blank   = 1'b1;
        end else if (cnt == hold_q) begin
          // direction was already flipped on the way in
          state_n = PLAY;
          cnt_n   = 1;
          enter   = 1'b1;
          col_n   = is_loop ? '0 : (dir ? col_idx - 1'b1 : col_idx + 1'b1);
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
`endif
      default: state_n = IDLE;
    endcase
    if (turn) begin
`ifdef BLANK_GAP_EN
      state_n = GAP;
      blank   = 1'b1;
`else
      enter = 1'b1;
      col_n = turn_col;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      col_idx <= '0;
      cnt     <= '0;
      dir     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      signals <= '0;
      mode_q  <= '0;
      len_q   <= '0;
      hold_q  <= '0;
    end else begin
      state   <= state_n;
      col_idx <= col_n;
      cnt     <= cnt_n;
      dir     <= dir_n;
      busy    <= busy_n;
      done    <= done_n;
      // read-first: mem write in the same cycle lands after this sample
      if (enter)      signals <= mem[col_n];
      else if (blank) signals <= '0;
      if (launch) begin
        mode_q <= mode;
        len_q  <= len;
        hold_q <= (hold == '0) ? HOLD_W'(1) : hold;
      end
    end
  end

endmodule

// File: tb/tb_bitmap_wave_player.sv
// Directed bench for bitmap_wave_player (default build): one-shot, loop, ping-pong,
// stop, ignored starts, hold=0, read-first writes and asynchronous reset.
module tb_bitmap_wave_player;
  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [11:0] wr_data;
  logic        start, stop;
  logic [1:0]  mode;
  logic [5:0]  len;
  logic [7:0]  hold;
  logic [11:0] signals;
  logic        busy, done;
  logic [4:0]  col_idx;

  int n_cmp = 0;
  int n_err = 0;
  logic [11:0] m [12];

  bitmap_wave_player #(.ROWS(12), .COLS(32), .HOLD_W(8)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .stop(stop), .mode(mode), .len(len), .hold(hold),
    .signals(signals), .busy(busy), .done(done), .col_idx(col_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [1:0] md, input logic [5:0] l, input logic [7:0] h);
    mode = md; len = l; hold = h; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic halt();
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("halt_busy", busy, 0);
    chk("halt_sig", signals, 0);
  endtask

  initial begin
    int ndone;
    int c;
    int pp_seq [14] = '{0,0,1,1,2,2,1,1,0,0,1,1,2,2};
    m = '{12'h070, 12'h0F8, 12'h1FC, 12'h3FE, 12'h7FE, 12'hFFC,
          12'hFFD, 12'h7FF, 12'h3FF, 12'h1FD, 12'h0F9, 12'h071};
    reset = 1'b0; wr_en = 0; wr_addr = '0; wr_data = '0;
    start = 0; stop = 0; mode = '0; len = '0; hold = '0;
    #3;
    chk("rst_sig", signals, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_col", col_idx, 0);
    #20 reset = 1'b1;
    step();

    for (int i = 0; i < 12; i++) begin
      wr_en = 1; wr_addr = 5'(i); wr_data = m[i];
      step();
    end
    wr_en = 0;

    // one-shot, 12 columns x 3 cycles, done at the 37th edge
    ndone = 0;
    go(2'b00, 6'd12, 8'd3);
    for (int t = 1; t <= 38; t++) begin
      if (t > 1) step();
      if (done) ndone++;
      if (t <= 36) begin
        chk("os_col", col_idx, (t-1)/3);
        chk("os_sig", signals, m[(t-1)/3]);
        chk("os_busy", busy, 1);
      end else if (t == 37) begin
        chk("os_done", done, 1);
        chk("os_end_busy", busy, 0);
        chk("os_end_sig", signals, 0);
      end else begin
        chk("os_done_clr", done, 0);
        chk("os_after_sig", signals, 0);
      end
    end
    chk("os_done_cnt", ndone, 1);

    // loop len 4 hold 1, then stop at cycle 5
    go(2'b01, 6'd4, 8'd1);
    for (int t = 1; t <= 5; t++) begin
      if (t > 1) step();
      chk("lp_col", col_idx, (t-1)%4);
      chk("lp_sig", signals, m[(t-1)%4]);
      chk("lp_done", done, 0);
    end
    halt();
    chk("lp_stop_done", done, 0);
    step();
    chk("lp_stop_done2", done, 0);
    chk("lp_stop_busy2", busy, 0);

    // ping-pong len 3 hold 2
    go(2'b10, 6'd3, 8'd2);
    for (int t = 1; t <= 14; t++) begin
      if (t > 1) step();
      chk("pp_col", col_idx, pp_seq[t-1]);
      chk("pp_sig", signals, m[pp_seq[t-1]]);
    end
    halt();

    // ping-pong len 1 holds column 0
    go(2'b10, 6'd1, 8'd1);
    for (int t = 1; t <= 6; t++) begin
      if (t > 1) step();
      chk("pp1_col", col_idx, 0);
      chk("pp1_busy", busy, 1);
      chk("pp1_sig", signals, m[0]);
    end
    halt();

    // start+stop together, len=0, len>COLS: all ignored
    stop = 1'b1;
    go(2'b01, 6'd4, 8'd1);
    stop = 1'b0;
    chk("ss_busy", busy, 0);
    go(2'b00, 6'd0, 8'd1);
    chk("len0_busy", busy, 0);
    step();
    chk("len0_done", done, 0);
    go(2'b00, 6'd33, 8'd1);
    chk("len33_busy", busy, 0);

    // hold=0 behaves as hold=1
    go(2'b00, 6'd2, 8'd0);
    chk("h0_c0", col_idx, 0);
    step();
    chk("h0_c1", col_idx, 1);
    chk("h0_s1", signals, m[1]);
    step();
    chk("h0_done", done, 1);

    // writes during playback: old data until column re-entered (read-first)
    go(2'b01, 6'd2, 8'd4);
    for (int t = 1; t <= 16; t++) begin
      if (t > 1) begin
        wr_en   = (t == 3 || t == 5);
        wr_addr = (t == 3) ? 5'd0 : 5'd1;
        wr_data = (t == 3) ? 12'hA5A : 12'h5A5;
        step();
        wr_en = 0;
      end
      c = ((t-1)/4) % 2;
      chk("wr_col", col_idx, c);
      if (c == 0) chk("wr_sig0", signals, (t <= 4) ? m[0] : 12'hA5A);
      else        chk("wr_sig1", signals, (t <= 8) ? m[1] : 12'h5A5);
    end
    m[0] = 12'hA5A;
    m[1] = 12'h5A5;
    halt();

    // asynchronous reset mid-column
    go(2'b01, 6'd4, 8'd5);
    for (int t = 2; t <= 7; t++) step();
    chk("ar_pre_col", col_idx, 1);
    #2 reset = 1'b0;
    #1;
    chk("ar_sig", signals, 0);
    chk("ar_busy", busy, 0);
    chk("ar_col", col_idx, 0);
    chk("ar_done", done, 0);
    #1 reset = 1'b1;
    step();
    go(2'b00, 6'd2, 8'd1);
    chk("ar_re_col", col_idx, 0);
    chk("ar_re_sig", signals, m[0]);
    chk("ar_re_busy", busy, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/bitmap_wave_player.md
# bitmap_wave_player

Parametrised bitmap waveform generator: drives `ROWS` parallel output lines so that a stored picture (e.g. the heart bitmap) appears in a waveform viewer, one bitmap column per time step. It is the configurable successor of the fixed 12-line heart pattern block. Compared with that block it adds:
- a writable column memory;
- per-column hold time;
- one-shot, loop and ping-pong playback;
- a start/stop/done handshake.

It sits directly under the top-level testbench or a display wrapper.

## Interface
Parameters:
- `ROWS`, 12, number of output lines (bitmap height).
- `COLS`, 32, column memory depth (maximum bitmap width).
- `HOLD_W`, 8, width of the hold-time field.

Ports (`AW` = $clog2(`COLS`)):
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `wr_en`  in  1  column memory write strobe.
- `wr_addr`  in  `AW`  column address to write.
- `wr_data`  in  `ROWS`  column bits; bit i drives `signals[i]`.
- `start`  in  1  start playback; honoured only in IDLE.
- `stop`  in  1  abort playback.
- `mode`  in  2  playback mode:
  - 00 one-shot
  - 01 loop
  - 10 ping-pong
  - 11 treated as one-shot
- `len`  in  `AW`+1  number of columns to play, 1..`COLS`.
- `hold`  in  `HOLD_W`  cycles each column is held; 0 is treated as 1.
- `signals`  out  `ROWS`  registered pattern outputs.
- `busy`  out  1  high while playing.
- `done`  out  1  one-cycle pulse at one-shot completion.
- `col_idx`  out  `AW`  index of the column currently shown.

## Operation
- States: IDLE, PLAY, and GAP (GAP exists only with `BLANK_GAP_EN`).
- Column memory: `COLS` x `ROWS`, synchronous write, no reset (contents undefined after power-up).
  - Writes are accepted in every state.
  - `signals` samples the memory only when a column is entered; a write to the shown column takes effect at the next entry of that column.
  - A write and a column entry on the same address in the same cycle → old data is shown (read-first).
- IDLE + `start`=1 + 1 ≤ `len` ≤ `COLS` → latch `mode`, `len` and `hold` (0 → 1), go to PLAY at column 0.
  - `start` with `len`=0 or `len`>`COLS` is ignored: stays IDLE, no `done`.
- PLAY: a hold counter counts 1..hold, then advances to the next column.
  - One-shot: after column `len`-1 completes → IDLE; `signals`=0, `busy`=0, `done`=1 for one cycle.
  - Loop: column `len`-1 → column 0, indefinitely.
  - Ping-pong: sequence 0,1,…,`len`-1,`len`-2,…,1,0,1,…; end columns are not repeated. `len`=1 holds column 0 forever.
- `stop`=1 in PLAY/GAP → IDLE at the next edge; `signals`=0, `busy`=0, no `done`.
- `start` and `stop` high together in IDLE → `stop` wins (stay IDLE).
- `start` while busy is ignored.
- Changes to `mode`/`len`/`hold` during playback are ignored until the next start.

## Timing
- Reset values: `signals`=0, `busy`=0, `done`=0, `col_idx`=0, state IDLE, hold counter 0. Reset asserted mid-playback clears all of these immediately (asynchronously).
- Start latency is 1 cycle: `start` sampled at edge N → at edge N+1 `busy`=1, `col_idx`=0, `signals`=mem[0].
- Each column is visible for exactly `hold` cycles (1 if `hold`=0). Column k is entered at edge N+1+k·hold in one-shot/loop.
- One-shot end: at edge N+1+`len`·hold → `signals`=0, `busy`=0, `done`=1. `done` returns to 0 at the following edge.
- A new `start` is accepted in the cycle `done` is high. Playback restarts at the next edge with no idle gap.
- `stop` latency is 1 cycle.
- Hold counter width is `HOLD_W`; `hold`=2^`HOLD_W`-1 must not wrap.

## Configuration
- `BLANK_GAP_EN` defined:
  - In loop mode, after column `len`-1 the block enters GAP for `hold` cycles, with `signals`=0 and `col_idx`=`len`-1, then resumes at column 0.
  - In ping-pong mode, GAP is inserted at each turnaround, after column `len`-1 and after column 0.
  - Separates repeated pictures visually.
- `BLANK_GAP_EN` undefined: GAP state absent; wrap-around is seamless as described in Operation.

## Test plan
- Reset held, then released; write 12 columns of the heart bitmap; start with `mode`=00, `len`=12, `hold`=3 → each column shown 3 cycles; `done` is pulsed exactly once at cycle 37 after start; `signals`=0 afterwards.
- `mode`=01, `len`=4, `hold`=1 → `col_idx` sequence 0,1,2,3,0,1…. With `BLANK_GAP_EN`, one blank cycle appears between 3 and 0.
- `mode`=10, `len`=3, `hold`=2 → `col_idx` sequence 0,0,1,1,2,2,1,1,0,0,1,1…; also `len`=1 → column 0 held forever.
- `stop` asserted at cycle 5 of a loop → `busy`=0 and `signals`=0 next cycle, `done` never set. Also `start`+`stop` together in IDLE → no start.
- Write to `col_idx`'s address during playback → old data shown until that column is re-entered. `start` with `len`=0 → ignored. `hold`=0 → behaves as `hold`=1.
- `reset` asserted asynchronously mid-column → all outputs 0 without waiting for `clk`. After release, `start` plays from column 0.
